// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter.
// Holds FSM states, parity modes and data-width helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD,
        PAR_MARK
    } parity_e;

    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    function automatic logic [3:0] data_bits_cnt(
        input logic [1:0] db
    );
        logic [3:0] n;
        n = 4'd8;
        unique case (db)
            DB_5: n = 4'd5;
            DB_6: n = 4'd6;
            DB_7: n = 4'd7;
            DB_8: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Small synchronous FIFO feeding the transmitter.
// Ports: push/pop with wdata/rdata, full/empty flags.
module uart_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data, parity, 1/2 stop).
// Ports: tx_valid/tx_data/tx_ready in, cfg_* frame setup, tx_serial out.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 tx_valid,
    input  logic [7:0]           tx_data,
    output logic                 tx_ready,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [1:0]           cfg_data_bits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_idle
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV =
        DIV_WIDTH'(CLK_FREQ / BAUD_RATE);

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [2:0]           r_bits;
    logic [2:0]           r_last;
    logic [7:0]           r_shift;
    parity_e              r_par_mode;
    logic                 r_stop2;
    logic                 r_par;
    logic                 r_serial;
    logic                 r_busy;

    logic                 w_full;
    logic                 w_empty;
    logic [7:0]           w_fifo_data;
    logic [DIV_WIDTH-1:0] w_cfg_div;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_pop;
    logic                 w_par_bit;

    uart_fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (tx_valid),
        .pop   (w_pop),
        .wdata (tx_data),
        .rdata (w_fifo_data),
        .full  (w_full),
        .empty (w_empty)
    );

    assign tx_ready  = !w_full;
    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_idle   = (r_state == IDLE) && w_empty;

    assign w_cfg_div = (cfg_div == '0) ? DEF_DIV : cfg_div;
    assign w_tick    = (r_cnt == r_div - 1'b1);

    // Second stop period is tracked in r_bits[0].
    assign w_last_stop = (r_state == STOP) && w_tick &&
                         (!r_stop2 || r_bits[0]);

    // Pop from IDLE or straight out of the last stop bit,
    // so frames chain without an idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || w_last_stop);

    always_comb begin
        w_par_bit = 1'b1;
        unique case (r_par_mode)
            PAR_EVEN: w_par_bit = r_par;
            PAR_ODD:  w_par_bit = !r_par;
            default:  w_par_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_bits     <= '0;
            r_last     <= '0;
            r_shift    <= '0;
            r_par_mode <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_par      <= 1'b0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (r_state != IDLE) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            end
            if (w_pop) begin
                r_shift    <= w_fifo_data;
                r_div      <= w_cfg_div;
                r_last     <= 3'(data_bits_cnt(cfg_data_bits) - 4'd1);
                r_par_mode <= parity_e'(cfg_parity);
                r_stop2    <= cfg_stop2;
                r_par      <= 1'b0;
                r_bits     <= '0;
                r_cnt      <= '0;
                r_serial   <= 1'b0;
                r_busy     <= 1'b1;
                r_state    <= START;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    START: if (w_tick) begin
                        r_serial <= r_shift[0];
                        r_par    <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bits   <= '0;
                        r_state  <= DATA;
                    end
                    DATA: if (w_tick) begin
                        if (r_bits == r_last) begin
                            r_bits <= '0;
                            if (r_par_mode != PAR_NONE) begin
                                r_serial <= w_par_bit;
                                r_state  <= PARITY;
                            end else begin
                                r_serial <= 1'b1;
                                r_state  <= STOP;
                            end
                        end else begin
                            r_bits   <= r_bits + 1'b1;
                            r_serial <= r_shift[0];
                            r_par    <= r_par ^ r_shift[0];
                            r_shift  <= r_shift >> 1;
                        end
                    end
                    PARITY: if (w_tick) begin
                        r_serial <= 1'b1;
                        r_bits   <= '0;
                        r_state  <= STOP;
                    end
                    STOP: if (w_tick) begin
                        if (w_last_stop) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_bits <= 3'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, chaining,
// default divisor and reset behaviour.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx_serial;
    logic        tx_busy;
    logic        tx_idle;

    int checks   = 0;
    int failures = 0;

    logic rec = 1'b0;
    logic q_ser[$];
    logic q_bsy[$];

    logic [7:0] w [6];

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .CLK_FREQ   (1000),
        .BAUD_RATE  (100),
        .DIV_WIDTH  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx_serial     (tx_serial),
        .tx_busy       (tx_busy),
        .tx_idle       (tx_idle)
    );

    always @(negedge clk) begin
        if (rec) begin
            q_ser.push_back(tx_serial);
            q_bsy.push_back(tx_busy);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        chk("push_ready", tx_ready, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_idle && n < max);
        chk("idle_wait", tx_idle, 1);
    endtask

    // bits[0] is the start bit; each bit spans div samples.
    task automatic check_rec(input logic [11:0] bits,
                             input int nb,
                             input int div,
                             input int base,
                             input string tag);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < div; k++) begin
                chk($sformatf("%s_b%0d_%0d", tag, b, k),
                    q_ser[base + b*div + k], bits[b]);
            end
        end
    endtask

    task automatic single(input string tag,
                          input logic [7:0] d,
                          input logic [1:0] db,
                          input logic [1:0] par,
                          input logic st,
                          input int div,
                          input logic [11:0] bits,
                          input int nb);
        int l;
        cfg_div       = 16'(div);
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = st;
        q_ser.delete();
        q_bsy.delete();
        push(d);
        rec = 1'b1;
        wait_idle(400);
        #1 rec = 1'b0;
        l = nb * div;
        chk({tag, "_len"}, q_ser.size(), l + 2);
        chk({tag, "_pre"}, q_ser[0], 1);
        check_rec(bits, nb, div, 1, tag);
        chk({tag, "_post"}, q_ser[l+1], 1);
        chk({tag, "_bsy0"}, q_bsy[0], 0);
        chk({tag, "_bsy1"}, q_bsy[1], 1);
        chk({tag, "_bsyL"}, q_bsy[l], 1);
        chk({tag, "_bsyE"}, q_bsy[l+1], 0);
    endtask

    initial begin
        int n;
        w[0] = 8'h01;
        w[1] = 8'h80;
        w[2] = 8'h7E;
        w[3] = 8'h3C;
        w[4] = 8'hF0;
        w[5] = 8'h5A;

        rst_          = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        cfg_div       = 16'd4;
        cfg_data_bits = 2'b11;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_serial", tx_serial, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_idle", tx_idle, 1);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        single("a5_8n1", 8'hA5, 2'b11, 2'b00, 1'b0, 4,
               {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
        // 7E2 0x55: data 1010101, parity 0, stops 11
        single("55_7e2", 8'h55, 2'b10, 2'b01, 1'b1, 4,
               {1'b0, 2'b11, 1'b0, 7'h55, 1'b0}, 11);
        // 5O1 0xFF: data 11111, parity 0
        single("ff_5o1", 8'hFF, 2'b00, 2'b10, 1'b0, 2,
               {4'h0, 1'b1, 1'b0, 5'h1F, 1'b0}, 8);
        // 5M1 0xFF: data 11111, parity 1
        single("ff_5m1", 8'hFF, 2'b00, 2'b11, 1'b0, 2,
               {4'h0, 1'b1, 1'b1, 5'h1F, 1'b0}, 8);

        // Back-to-back 8N1, div 3, six words
        cfg_div       = 16'd3;
        cfg_data_bits = 2'b11;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        q_ser.delete();
        q_bsy.delete();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = w[0];
        chk("b2b_rdy0", tx_ready, 1);
        @(posedge clk);
        #1 rec = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            tx_data = w[i];
            chk($sformatf("b2b_rdy%0d", i), tx_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        tx_data = w[5];
        chk("b2b_full", tx_ready, 0);
        n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_wait", n, 27);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_idle(400);
        #1 rec = 1'b0;
        chk("b2b_len", q_ser.size(), 182);
        chk("b2b_pre", q_ser[0], 1);
        for (int f = 0; f < 6; f++) begin
            check_rec({2'b00, 1'b1, w[f], 1'b0}, 10, 3,
                      1 + 30*f, $sformatf("b2b_f%0d", f));
        end
        chk("b2b_post", q_ser[181], 1);
        for (int i = 1; i <= 180; i++) begin
            chk($sformatf("b2b_bsy%0d", i), q_bsy[i], 1);
        end
        chk("b2b_bsyE", q_bsy[181], 0);

        // Default divisor (10) then mid-frame change to 2
        cfg_div = 16'd0;
        q_ser.delete();
        q_bsy.delete();
        push(8'h3C);
        rec = 1'b1;
        push(8'hC3);
        repeat (30) @(negedge clk);
        cfg_div = 16'd2;
        wait_idle(400);
        #1 rec = 1'b0;
        chk("div0_len", q_ser.size(), 122);
        chk("div0_pre", q_ser[0], 1);
        check_rec({2'b00, 1'b1, 8'h3C, 1'b0}, 10, 10, 1,
                  "div0_f0");
        check_rec({2'b00, 1'b1, 8'hC3, 1'b0}, 10, 2, 101,
                  "div0_f1");
        chk("div0_post", q_ser[121], 1);
        chk("div0_bsy", q_bsy[101], 1);
        chk("div0_bsyE", q_bsy[121], 0);

        // Reset during data bit 0 with a word still queued
        cfg_div = 16'd4;
        push(8'h00);
        push(8'h11);
        repeat (6) @(negedge clk);
        chk("mrst_pre_ser", tx_serial, 0);
        chk("mrst_pre_bsy", tx_busy, 1);
        chk("mrst_pre_idle", tx_idle, 0);
        #2 rst_ = 1'b0;
        #1;
        chk("mrst_ser", tx_serial, 1);
        chk("mrst_bsy", tx_busy, 0);
        chk("mrst_idle", tx_idle, 1);
        chk("mrst_rdy", tx_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_after_ser", tx_serial, 1);
        chk("mrst_after_idle", tx_idle, 1);
        chk("mrst_after_bsy", tx_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It accepts bytes through a valid/ready handshake into a small internal FIFO, then serialises them as frames with 5 to 8 data bits, optional parity and 1 or 2 stop bits. Consecutive frames go out back-to-back with no idle gap. It replaces the fixed 8N1 transmitter wherever a host-configurable serial port is needed.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, fallback baud rate, used when cfg_div==0 (DEF_DIV = CLK_FREQ/BAUD_RATE).
DIV_WIDTH, 16, width of the runtime baud divisor.
FIFO_DEPTH, 4, entries in the transmit FIFO; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; single clock domain.
rst_  in  1  asynchronous, active-low reset.
tx_valid  in  1  data-valid qualifier for tx_data.
tx_data  in  8  byte to send; bits above the configured data width are ignored.
tx_ready  out  1  high when the FIFO can accept a word (not full).
cfg_div  in  DIV_WIDTH  clocks per bit; 0 selects DEF_DIV.
cfg_data_bits  in  2  data width: 00=5, 01=6, 10=7, 11=8.
cfg_parity  in  2  00=none, 01=even, 10=odd, 11=mark (constant 1).
cfg_stop2  in  1  0=one stop bit, 1=two stop bits.
tx_serial  out  1  serial line; idles high.
tx_busy  out  1  high while the FSM is not IDLE.
tx_idle  out  1  high when the FSM is IDLE and the FIFO is empty.

Behaviour:
- Reset (async, rst_ low): tx_serial=1, tx_busy=0, tx_idle=1, tx_ready=1, FIFO emptied, state=IDLE, baud counter=0, bit counter=0.
- Reset mid-frame: the line returns high immediately and queued words are discarded.
- Push: a word is written on any edge where tx_valid && tx_ready. tx_ready = !full.
- Push when full is impossible (tx_ready low); tx_valid with tx_ready low is ignored.
- Push and pop on the same edge: both take effect and the count is unchanged.
- Frame config (cfg_div resolved, data bits, parity, stop2) is latched at the pop edge. Config changes mid-frame take effect on the next frame only.
- Bit timing: every bit lasts exactly DIV clocks. The baud counter counts 0..DIV-1; the bit ends on the edge where the count equals DIV-1, and the counter then wraps to 0. DIV=1 gives one clock per bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is not empty, pop, load the shifter and config, set tx_serial=0 and go to START on the same edge.
  - START: after DIV clocks go to DATA and drive data bit 0.
  - DATA: send bits LSB first, shifting right. After bit N-1 go to PARITY if parity is enabled, else to STOP.
  - PARITY: even = XOR of the N sent bits; odd = its inverse; mark = 1. Lasts DIV clocks, then go to STOP.
  - STOP: drive 1 for DIV clocks (2*DIV if stop2). At the end, if the FIFO is not empty, pop and enter START on the same edge with tx_serial=0 (no idle gap); otherwise go to IDLE.
- Latency: a word accepted at edge E0 into an empty FIFO while IDLE causes tx_serial=0 from edge E1.
- Outputs: tx_serial is registered. tx_busy is registered and high from the pop edge until return to IDLE. tx_idle is derived from registered state.
- Frame length = (1 + N + P + S) * DIV clocks, where P is 0 or 1 and S is 1 or 2.

Decomposition:
- Package uart_pkg holds:
  - state_t: IDLE, START, DATA, PARITY, STOP.
  - parity_e: PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK.
  - data_bits encoding constants and a data-bits-to-count function.
- Sub-module uart_fifo_sync: parametrised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty, async active-low reset on rst_.

Test Plan:
- Reset: hold rst_ low 3 cycles -> tx_serial=1, tx_ready=1, tx_busy=0, tx_idle=1. Assert rst_ low mid data bit -> tx_serial=1 in the same cycle and the FIFO is empty afterwards.
- 8N1, cfg_div=4, push 0xA5 -> 0 for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks; total 40 clocks; tx_serial low at E0+1.
- 7E2, cfg_div=4, push 0x55 -> data 1,0,1,0,1,0,1; parity 0; two stop bits; 44 clocks; tx_busy falls after the last stop.
- 5O1, cfg_div=2, push 0xFF -> data 1,1,1,1,1; parity 0; one stop; 16 clocks. Repeat with 5M1 -> parity 1.
- Back-to-back: cfg_div=3, 8N1, push 6 words on consecutive cycles -> tx_ready drops after the 5th accept. The 6th word is accepted when the first frame ends. Six frames go out with no idle high between the stop bit and the next start; byte order is preserved.
- cfg_div=0 with CLK_FREQ=1000, BAUD_RATE=100 -> 10 clocks per bit. Change cfg_div to 2 mid-frame -> the current frame keeps 10, the next frame uses 2.
